// File: rtl/pwm_capture.sv
// PWM input capture: measures high time and period of pwm_in in clk cycles,
// publishes each completed measurement to read-only registers and raises a 4-phase interrupt.
module pwm_capture #(
  parameter int COUNT_BITS = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pwm_in,
  input  logic                 rd_en,
  input  logic [2:0]           rd_addr,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 int_req,
  input  logic                 int_ack
);

  localparam int HB = COUNT_BITS - 8;
  localparam logic [COUNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [COUNT_BITS-1:0] CNT_ONE = COUNT_BITS'(1);

  typedef enum logic [1:0] {M_IDLE, M_HIGH, M_LOW} meas_t;
  typedef enum logic [1:0] {IRQ_IDLE, IRQ_REQ, IRQ_WAIT} irq_t;

  logic                  sync1_q, s_in_q, s_prev_q;
  meas_t                 meas_q, meas_d;
  irq_t                  irq_q, irq_d;
  logic [COUNT_BITS-1:0] hcnt_q, hcnt_d, pcnt_q, pcnt_d;
  logic [COUNT_BITS-1:0] high_q, high_d, period_q, period_d;
  logic [HB-1:0]         shadow_q, shadow_d;
  logic                  sat_q, sat_d, ovf_q, ovf_d;
  logic                  valid_q, valid_d, overrun_q, overrun_d;
  logic                  pend_q, pend_d;
  logic [DATA_BITS-1:0]  rd_data_q, rd_data_d;

  logic rise, fall, publish, status_rd, valid_eff, overrun_eff;

  assign rise      = s_in_q & ~s_prev_q;
  assign fall      = ~s_in_q & s_prev_q;
  assign publish   = (meas_q == M_LOW) && rise;
  assign status_rd = rd_en && (rd_addr == 3'd4);
  assign rd_data   = rd_data_q;
  assign int_req   = (irq_q == IRQ_REQ);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 1'b0;
      s_in_q    <= 1'b0;
      s_prev_q  <= 1'b0;
      meas_q    <= M_IDLE;
      irq_q     <= IRQ_IDLE;
      hcnt_q    <= '0;
      pcnt_q    <= '0;
      high_q    <= '0;
      period_q  <= '0;
      shadow_q  <= '0;
      sat_q     <= 1'b0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      pend_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      sync1_q   <= pwm_in;
      s_in_q    <= sync1_q;
      s_prev_q  <= s_in_q;
      meas_q    <= meas_d;
      irq_q     <= irq_d;
      hcnt_q    <= hcnt_d;
      pcnt_q    <= pcnt_d;
      high_q    <= high_d;
      period_q  <= period_d;
      shadow_q  <= shadow_d;
      sat_q     <= sat_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      pend_q    <= pend_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Measurement FSM with saturating counters
  always_comb begin
    meas_d = meas_q;
    hcnt_d = hcnt_q;
    pcnt_d = pcnt_q;
    sat_d  = sat_q;
    case (meas_q)
      M_IDLE, M_LOW: begin
        if (rise) begin
          meas_d = M_HIGH;
          hcnt_d = CNT_ONE;
          pcnt_d = CNT_ONE;
          sat_d  = 1'b0;
        end else if (meas_q == M_LOW) begin
          if (pcnt_q == CNT_MAX) sat_d = 1'b1;
          else                   pcnt_d = pcnt_q + CNT_ONE;
        end
      end
      M_HIGH: begin
        if (pcnt_q == CNT_MAX) sat_d = 1'b1;
        else                   pcnt_d = pcnt_q + CNT_ONE;
        if (fall) begin
          meas_d = M_LOW;
        end else if (hcnt_q == CNT_MAX) begin
          sat_d = 1'b1;
        end else begin
          hcnt_d = hcnt_q + CNT_ONE;
        end
      end
      default: meas_d = M_IDLE;
    endcase
  end

  // Register file: reads see pre-publish values; a coincident status read is ordered before the publish
  always_comb begin
    rd_data_d   = rd_data_q;
    shadow_d    = shadow_q;
    high_d      = high_q;
    period_d    = period_q;
    ovf_d       = ovf_q;
    valid_eff   = status_rd ? 1'b0 : valid_q;
    overrun_eff = status_rd ? 1'b0 : overrun_q;
    if (rd_en) begin
      case (rd_addr)
        3'd0: begin
          rd_data_d = DATA_BITS'(high_q[7:0]);
          shadow_d  = high_q[COUNT_BITS-1:8];
        end
        3'd2: begin
          rd_data_d = DATA_BITS'(period_q[7:0]);
          shadow_d  = period_q[COUNT_BITS-1:8];
        end
        3'd1, 3'd3: rd_data_d = DATA_BITS'(shadow_q);
        3'd4:       rd_data_d = DATA_BITS'({4'b0000, s_in_q, ovf_q, overrun_q, valid_q});
        default:    rd_data_d = '0;
      endcase
    end
    valid_d   = valid_eff;
    overrun_d = overrun_eff;
    if (publish) begin
      high_d    = hcnt_q;
      period_d  = pcnt_q;
      ovf_d     = sat_q;
      valid_d   = 1'b1;
      overrun_d = overrun_eff | valid_eff;
    end
  end

  // Interrupt handshake: one request outstanding, later publishes fold into pend
  always_comb begin
    irq_d  = irq_q;
    pend_d = pend_q;
    case (irq_q)
      IRQ_IDLE: begin
        if (publish || pend_q) begin
          irq_d  = IRQ_REQ;
          pend_d = 1'b0;
        end
      end
      IRQ_REQ: begin
        if (int_ack) irq_d = IRQ_WAIT;
        if (publish) pend_d = 1'b1;
      end
      IRQ_WAIT: begin
        if (!int_ack) irq_d = IRQ_IDLE;
        if (publish)  pend_d = 1'b1;
      end
      default: irq_d = IRQ_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: table vectors, handshake/overrun/saturation/reset sequences,
// and random periods checked against a period-level model of the register file.
module tb_pwm_capture;

  localparam int MAX = 65535;

  typedef logic [4:0][7:0] bytes_t;
  typedef struct {
    int     h;
    int     l;
    int     off;
    bit     chk;
    bytes_t exp_b;
    bit     exp_irq;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset, pwm_in, rd_en, int_ack, int_req;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: the open period and the published register view
  int last_h, last_l;
  bit have_last;
  int m_high, m_per;
  bit m_ovf, m_valid, m_overrun, m_req;

  pwm_capture #(.COUNT_BITS(16), .DATA_BITS(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .pwm_in (pwm_in),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .int_req(int_req),
    .int_ack(int_ack)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // one cycle with pwm_in held low; extends the open low phase
  task automatic tick();
    cyc();
    if (have_last) last_l++;
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, got);
    end
  endtask

  task automatic rd(input int a, output logic [7:0] d);
    rd_en   = 1'b1;
    rd_addr = a[2:0];
    tick();
    rd_en   = 1'b0;
    d       = rd_data;
  endtask

  task automatic model_reset();
    have_last = 0; last_h = 0; last_l = 0;
    m_high = 0; m_per = 0;
    m_ovf = 0; m_valid = 0; m_overrun = 0; m_req = 0;
  endtask

  function automatic vec_t mk(input int h, input int l, input int off, input bit chk,
                              input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [7:0] b4, input bit irq);
    vec_t v;
    v.h = h; v.l = l; v.off = off; v.chk = chk;
    v.exp_b[0] = b0; v.exp_b[1] = b1; v.exp_b[2] = b2; v.exp_b[3] = b3; v.exp_b[4] = b4;
    v.exp_irq = irq;
    return v;
  endfunction

  // One PWM period (h high, l low). Its rise publishes the previous period.
  // With chk, addresses 0..4 are read at cycles off..off+4 of this period.
  task automatic run_period(input int h, input int l, input int off, input bit chk,
                            output bytes_t got, output bytes_t expv, output logic irq);
    int old_h, old_p, sum, a0, a2, n;
    bit s_bit;
    old_h = m_high;
    old_p = m_per;
    if (have_last) begin
      sum       = last_h + last_l;
      m_overrun = m_overrun | m_valid;
      m_valid   = 1'b1;
      m_high    = (last_h > MAX) ? MAX : last_h;
      m_per     = (sum > MAX) ? MAX : sum;
      m_ovf     = (sum > MAX);
      m_req     = 1'b1;
    end
    // the publish becomes visible from cycle 3 of the new period
    a0    = (off >= 3) ? m_high : old_h;
    a2    = (off + 2 >= 3) ? m_per : old_p;
    s_bit = (off + 2 < h);
    expv[0] = 8'(a0);
    expv[1] = 8'(a0 >> 8);
    expv[2] = 8'(a2);
    expv[3] = 8'(a2 >> 8);
    expv[4] = {4'b0000, s_bit, m_ovf, m_overrun, m_valid};
    if (chk) begin
      m_valid   = 1'b0;
      m_overrun = 1'b0;
    end
    got = '0;
    irq = 1'b0;
    n   = h + l;
    for (int c = 0; c < n; c++) begin
      pwm_in = (c < h);
      if (chk && c >= off && c <= off + 4) begin
        rd_en   = 1'b1;
        rd_addr = 3'(c - off);
      end else begin
        rd_en = 1'b0;
      end
      cyc();
      if (chk && c >= off && c <= off + 4) got[c - off] = rd_data;
      if (chk && c == off + 4) irq = int_req;
    end
    rd_en     = 1'b0;
    last_h    = h;
    last_l    = l;
    have_last = 1;
  endtask

  vec_t       tbl[8];
  bytes_t     got, expv;
  logic       irq;
  logic [7:0] d;
  int         h, l, off;
  bit         chk;

  initial begin
    reset = 1'b0; pwm_in = 1'b0; rd_en = 1'b0; rd_addr = 3'd0; int_ack = 1'b0;
    model_reset();

    tbl[0] = mk(64, 192, 4, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 0);
    tbl[1] = mk(64, 192, 4, 1, 8'h40, 8'h00, 8'h00, 8'h01, 8'h09, 1);
    tbl[2] = mk(3,  20,  4, 1, 8'h40, 8'h00, 8'h00, 8'h01, 8'h01, 1);
    tbl[3] = mk(1,  1,   0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    tbl[4] = mk(1,  30,  4, 1, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 1);
    tbl[5] = mk(20, 1,   4, 1, 8'h01, 8'h00, 8'h1F, 8'h00, 8'h09, 1);
    tbl[6] = mk(300, 5,  0, 1, 8'h01, 8'h00, 8'h1F, 8'h00, 8'h09, 1);
    tbl[7] = mk(30, 10,  4, 1, 8'h2C, 8'h01, 8'h31, 8'h01, 8'h09, 1);

    repeat (3) cyc();
    check("rst_rd_data", int'(rd_data), 0);
    check("rst_int_req", int'(int_req), 0);
    reset = 1'b1;
    cyc();

    foreach (tbl[i]) begin
      run_period(tbl[i].h, tbl[i].l, tbl[i].off, tbl[i].chk, got, expv, irq);
      if (tbl[i].chk) begin
        for (int k = 0; k < 5; k++)
          check($sformatf("tbl%0d_addr%0d", i, k), int'(got[k]), int'(tbl[i].exp_b[k]));
        check($sformatf("tbl%0d_irq", i), int'(irq), int'(tbl[i].exp_irq));
      end
    end

    // handshake, including a publish folded into pend while int_ack is high
    check("irq_pending", int'(int_req), 1);
    repeat (10) tick();
    check("irq_hold_no_ack", int'(int_req), 1);
    int_ack = 1'b1;
    tick();
    check("irq_drop_on_ack", int'(int_req), 0);
    run_period(10, 10, 0, 0, got, expv, irq);
    check("irq_pend_no_extra", int'(int_req), 0);
    int_ack = 1'b0;
    tick();
    check("irq_pend_idle", int'(int_req), 0);
    tick();
    check("irq_pend_reassert", int'(int_req), 1);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    tick();
    tick();
    check("irq_idle_after_pend", int'(int_req), 0);
    m_req = 1'b0;

    // overrun: a second publish without a status read in between
    run_period(12, 12, 4, 0, got, expv, irq);
    rd(4, d);
    check("ovr_status", int'(d), int'({4'b0000, 1'b0, m_ovf, m_overrun, m_valid}));
    check("ovr_status_const", int'(d), 8'h03);
    m_valid = 1'b0; m_overrun = 1'b0;
    tick();
    check("rd_data_held", int'(rd_data), 8'h03);
    rd(4, d);
    check("ovr_reread", int'(d), 8'h00);
    for (int a = 5; a < 8; a++) begin
      rd(a, d);
      check($sformatf("addr%0d_zero", a), int'(d), 0);
    end

    // random periods against the model
    for (int i = 0; i < 30; i++) begin
      h   = $urandom_range(1, 150);
      l   = $urandom_range(1, 150);
      off = $urandom_range(0, 4);
      chk = (h + l >= off + 5) && ($urandom_range(0, 3) != 0);
      run_period(h, l, off, chk, got, expv, irq);
      if (chk) begin
        for (int k = 0; k < 5; k++)
          check($sformatf("rnd%0d_h%0d_l%0d_off%0d_addr%0d", i, h, l, off, k),
                int'(got[k]), int'(expv[k]));
        check($sformatf("rnd%0d_irq", i), int'(irq), int'(m_req));
      end
    end

    // saturation and recovery
    run_period(70000, 10, 4, 0, got, expv, irq);
    run_period(20, 20, 4, 1, got, expv, irq);
    for (int k = 0; k < 5; k++)
      check($sformatf("sat_addr%0d", k), int'(got[k]), int'(expv[k]));
    check("sat_high_lo", int'(got[0]), 8'hFF);
    check("sat_period_hi", int'(got[3]), 8'hFF);
    check("sat_ovf", int'(got[4][2]), 1);
    run_period(20, 20, 4, 1, got, expv, irq);
    check("sat_clear_ovf", int'(got[4][2]), 0);
    check("sat_clear_period", int'(got[2]), 8'd40);

    // reset in the middle of a high phase with a request outstanding
    pwm_in = 1'b1;
    repeat (6) cyc();
    check("mid_irq_before", int'(int_req), 1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_irq_async", int'(int_req), 0);
    check("mid_rst_rd_data", int'(rd_data), 0);
    pwm_in = 1'b0;
    repeat (3) cyc();
    reset = 1'b1;
    model_reset();
    cyc();
    for (int a = 0; a < 5; a++) begin
      rd(a, d);
      check($sformatf("post_rst_addr%0d", a), int'(d), 0);
    end
    run_period(20, 20, 4, 1, got, expv, irq);
    for (int k = 0; k < 5; k++)
      check($sformatf("post_rst_first_addr%0d", k), int'(got[k]), int'(expv[k]));
    check("post_rst_first_irq", int'(irq), 0);
    run_period(20, 20, 4, 1, got, expv, irq);
    for (int k = 0; k < 5; k++)
      check($sformatf("post_rst_second_addr%0d", k), int'(got[k]), int'(expv[k]));
    check("post_rst_second_irq", int'(irq), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Memory-mapped PWM input-capture peripheral, the receive-side counterpart of `pwm_driver`. It measures the high time and period of an external PWM signal in clock cycles. It publishes each completed measurement into read-only registers on the `memory_io_mux` read path. It signals the execution unit over the `int_req`/`int_ack` four-phase handshake.

## Interface
- `COUNT_BITS`, 16: width of the high-time and period counters; must be 9..16.
- `DATA_BITS`, 8: CPU data width.
- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `pwm_in` in 1: asynchronous external PWM input.
- `rd_en` in 1: register read strobe from `memory_io_mux`.
- `rd_addr` in 3: register select.
- `rd_data` out `DATA_BITS`: registered read data.
- `int_req` out 1: interrupt request to the execution unit.
- `int_ack` in 1: interrupt acknowledge from the execution unit.

## Operation
- **Input synchronizer.** `pwm_in` passes through a 2-flop synchronizer to produce `s_in`. A third flop holds `s_prev`.
  - rise = `s_in & ~s_prev`
  - fall = `~s_in & s_prev`
- **Measurement FSM.** States are IDLE, HIGH and LOW.
  - IDLE: on rise, go to HIGH and set `hcnt`=1, `pcnt`=1. No publish.
  - HIGH: increment `pcnt` and `hcnt` every cycle. On fall, go to LOW.
  - LOW: increment `pcnt` every cycle. On rise, publish, go to HIGH, and set `hcnt`=1, `pcnt`=1.
- **Counter saturation.** Both counters saturate at 2^COUNT_BITS-1 and never wrap. A sticky `sat` flag is set when either counter saturates; it is cleared when a new measurement starts.
- **Publish (single cycle).**
  - Load `high_reg`←`hcnt` and `period_reg`←`pcnt`.
  - Set `ovf`←`sat`.
  - Set `valid`=1.
  - If `valid` was already 1, set `overrun`=1.
  - Post one interrupt event.
- **Register map**, read via `rd_addr`:
  - 0: `high_reg[7:0]`. The read also copies `high_reg[COUNT_BITS-1:8]` into `shadow`.
  - 1: `shadow`.
  - 2: `period_reg[7:0]`. The read also copies `period_reg[COUNT_BITS-1:8]` into `shadow`.
  - 3: `shadow`.
  - 4: status = {4'b0, `s_in`, `ovf`, `overrun`, `valid`}. The read clears `valid` and `overrun` (not `ovf`).
  - 5-7: return 0.
  - Upper shadow bits above COUNT_BITS-8 read 0.
- **Interrupt FSM.** States are IRQ_IDLE, IRQ_REQ and IRQ_WAIT.
  - IRQ_IDLE: on a publish or `pend`=1, go to IRQ_REQ, assert `int_req`, and clear `pend`.
  - IRQ_REQ: `int_req`=1. When `int_ack`=1 is sampled, go to IRQ_WAIT.
  - IRQ_WAIT: `int_req`=0. When `int_ack`=0 is sampled, go to IRQ_IDLE.
  - A publish in IRQ_REQ or IRQ_WAIT sets `pend`=1 and posts no extra request. At most one request is ever outstanding.

## Timing
- **Reset values.**
  - FSMs in IDLE / IRQ_IDLE.
  - All counters, registers, `shadow`, flags and `pend` are 0.
  - Outputs: `rd_data`=0, `int_req`=0.
- **Reset mid-operation.** Asserting reset abandons any partial measurement, drops `int_req` immediately (asynchronously) and returns everything to reset values.
- **Input latency.** An edge on `pwm_in` is detected 3 rising `clk` edges later (rise/fall combinational on that cycle).
- **Publish latency.**
  - Registers update on the clock edge ending the rise-detect cycle.
  - `int_req` rises on that same edge when in IRQ_IDLE.
- **Measurement values.** `hcnt` equals the number of cycles `s_in`=1 within the period. `pcnt` equals the number of cycles between consecutive rises. Both are exact up to saturation.
- **Read timing.**
  - `rd_data` is registered: valid on the cycle after `rd_en`=1 and held while `rd_en`=0.
  - Read side effects (shadow copy, status clear) apply on that same edge.
- **Simultaneous read and publish.** If a status read coincides with a publish, the publish wins: `valid`=1, and `overrun` is set as if the read happened first. The read returns pre-publish values.
- **Simultaneous low-byte read and publish.** A read of address 0 or 2 in the publish cycle returns the old low byte and copies the old high byte into `shadow`.
- **Minimum pulse.** Pulses shorter than 2 cycles may be missed. A high or low phase of exactly 1 synchronized cycle is measured correctly.

## Test plan
- **Nominal capture.** After reset, drive `pwm_in` as 64 high / 192 low repeatedly.
  - The first rise does not publish.
  - The second rise publishes `high_reg`=64 and `period_reg`=256.
  - Reads of addr 0,1,2,3 return 0x40, 0x00, 0x00, 0x01.
  - Status = 0x01 (with `s_in` bit as sampled).
- **Interrupt handshake.**
  - After a publish, `int_req`=1.
  - Hold `int_ack`=0 for 10 cycles: `int_req` stays 1.
  - Raise `int_ack`: `int_req` drops the next cycle.
  - A second publish while `int_ack` is still high: `int_req` re-asserts only after `int_ack` returns to 0 (pend path).
- **Overrun.** Let two measurements publish without reading status.
  - Status = 0x03.
  - Re-reading status gives 0x00 or 0x08 depending on the level of `pwm_in`.
- **Saturation.** Hold `pwm_in` high for 70000 cycles, then use a 10-cycle low.
  - The published `high_reg` and `period_reg` are both 0xFFFF and `ovf`=1.
  - The next normal period clears `ovf`.
- **Shadow coherence.**
  - Read addr 2 in the publish cycle, then addr 3: the bytes come from the same old period value.
  - Reads of addr 5-7 return 0.
- **Reset mid-measurement.** Assert reset while in HIGH with `int_req`=1.
  - `int_req`=0 immediately.
  - After release, all registers read 0.
  - The first subsequent rise does not publish.
